mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multicycle main-control FSM for the MIPS core.
- Sequences the shared datapath: one ALU, one memory port, the register file and the PC.
- Decodes the 6-bit opcode from the instruction register.
- Drives the 3-bit aluop consumed by the ALU-control decoder, plus all mux selects and write enables, one state per cycle.

Parameters:
- none: opcode encodings and state codes are constants in the shared package.

Ports:
- clk  in  1  core clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from the instruction register; stable from DECODE until the next FETCH
- zero  in  1  ALU zero flag, same cycle
- pcen  out  1  PC write enable = pcwrite | (beq_st & zero) | (bne_st & ~zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  destination register select: 1 = rd, 0 = rt
- memtoreg  out  1  register-file write data select: 1 = MDR, 0 = ALUOut
- regwrite  out  1  register-file write enable
- alusrca  out  1  ALU A input select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B input select: 00 = rt, 01 = const 4, 10 = immediate, 11 = sign-extended immediate << 2
- zeroext  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  out  3  000 add, 001 sub, 010 use funct, 011 or, 100 xor
- illegal  out  1  one-cycle pulse on an unknown opcode
- state  out  4  current state, for debug

Behaviour:
- Moore FSM. All outputs decode from the state register only (zero only enters pcen).
- Any output not listed for a state is 0.
- Reset:
  - rst=1 at a rising edge loads state=FETCH.
  - While rst=1, every write enable is forced to 0 (pcen, memwrite, irwrite, regwrite) and illegal=0.
  - Selects still follow the state code.
  - rst asserted mid-instruction abandons it; FETCH follows the next edge; no partial write is issued.
- States (code: outputs -> next state):
  - FETCH(0): irwrite=1, pcwrite=1, alusrcb=01, aluop=000 -> DECODE
  - DECODE(1): alusrcb=11, aluop=000 -> by op:
    - lw(100011) / sw(101011) -> MEMADR
    - R-type(000000) -> RTYPEEX
    - beq(000100) -> BEQ
    - bne(000101) -> BNE
    - addi(001000) / ori(001101) / xori(001110) -> IMMEX
    - j(000010) -> JUMP
    - any other op -> FETCH, with illegal=1 during DECODE
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=000 -> MEMRD if lw, MEMWR if sw
  - MEMRD(3): iord=1 -> MEMWB
  - MEMWB(4): memtoreg=1, regwrite=1 -> FETCH
  - MEMWR(5): iord=1, memwrite=1 -> FETCH
  - RTYPEEX(6): alusrca=1, alusrcb=00, aluop=010 -> RTYPEWB
  - RTYPEWB(7): regdst=1, regwrite=1 -> FETCH
  - BEQ(8): alusrca=1, aluop=001, pcsrc=01, pcen=zero -> FETCH
  - BNE(12): as BEQ but pcen=~zero -> FETCH
  - IMMEX(9): alusrca=1, alusrcb=10; aluop = 000 for addi, 011 for ori, 100 for xori; zeroext=1 for ori/xori -> IMMWB
  - IMMWB(10): regwrite=1 -> FETCH
  - JUMP(11): pcsrc=10, pcen=1 -> FETCH
- Unused codes 13–15 -> FETCH with all enables 0.
- Cycle counts: lw 5; sw, R-type, immediate ops 4; beq, bne, j 3; illegal 2.

Optional Feature:
- MC_CTRL_MEM_WAIT_EN defined:
  - Adds input mem_ready (1 bit).
  - FETCH, MEMRD and MEMWR hold their state while mem_ready=0.
  - In FETCH, irwrite/pcwrite assert only in the cycle mem_ready=1.
  - memwrite stays high throughout the MEMWR hold.
  - MEMRD leaves on mem_ready=1.
  - rst overrides the wait.
- Undefined: no mem_ready port; memory is treated as always ready, giving the timing above.

Decomposition:
- Package mc_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_XORI, OP_J)
  - aluop constants (ALUOP_ADD=000, SUB=001, FUNCT=010, OR=011, XOR=100), shared with the ALU-control decoder
- No sub-module: next-state logic and output decode are both in mc_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles -> pcen=irwrite=regwrite=memwrite=0; after release, state=0 and irwrite=1 on the first cycle.
- lw (op=100011):
  - state sequence 0,1,2,3,4.
  - In MEMADR: aluop=000, alusrcb=10.
  - In MEMWB: regwrite=1, memtoreg=1.
  - State 0 again on cycle 6.
- R-type (op=000000) -> RTYPEEX with aluop=010, alusrcb=00; then RTYPEWB with regdst=1, regwrite=1; 4 cycles total.
- Branches: beq with zero=1 -> pcen=1, pcsrc=01 in state 8; beq with zero=0 -> pcen=0; bne with zero=0 -> pcen=1.
- Immediates and illegal op:
  - ori -> IMMEX aluop=011, zeroext=1.
  - xori -> aluop=100.
  - op=111111 -> illegal=1 for one cycle in DECODE, then FETCH with no writes.
- MC_CTRL_MEM_WAIT_EN:
  - sw with mem_ready low 3 cycles in MEMWR -> memwrite high for 4 cycles, then FETCH.
  - rst asserted during a FETCH hold -> FETCH with enables 0.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: constants shared by the multicycle MIPS main control (mc_ctrl)
// and the ALU-control decoder.
//   - state_t   : FSM state encodings (also exported on mc_ctrl.state)
//   - OP_*      : 6-bit primary opcodes, instr[31:26]
//   - ALUOP_*   : 3-bit aluop codes consumed by the ALU-control decoder
//   - op_is_legal() : true for every opcode the controller implements
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_XOR   = 3'b100;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ORI, OP_XORI, OP_LW, OP_SW: op_is_legal = 1'b1;
      default:                       op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main-control FSM for the MIPS core. One state per
// cycle sequences the shared ALU, memory port, register file and PC.
//
// Ports:
//   clk, rst      : core clock; synchronous active-high reset (-> FETCH)
//   op[5:0]       : instr[31:26], stable from DECODE until the next FETCH
//   mem_ready     : only with MC_CTRL_MEM_WAIT_EN; FETCH/MEMRD/MEMWR hold
//                   while it is low
//   zero          : ALU zero flag, used only by the branch PC enable
//   pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb[1:0], zeroext, pcsrc[1:0], aluop[2:0]
//                 : datapath enables / selects, decoded from the state
//   illegal       : one-cycle pulse in DECODE on an unknown opcode
//   state[3:0]    : current state code, for debug
//
// Build option: define MC_CTRL_MEM_WAIT_EN to add the mem_ready handshake.
// Without it the memory is treated as always ready.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  logic   mem_rdy;

  // Raw (pre-reset-gating) enables produced by the state decode.
  logic pcwrite_raw;
  logic beq_st;
  logic bne_st;
  logic memwrite_raw;
  logic irwrite_raw;
  logic regwrite_raw;
  logic illegal_raw;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = S_FETCH;
    pcwrite_raw  = 1'b0;
    beq_st       = 1'b0;
    bne_st       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    zeroext      = 1'b0;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        // PC+4 and the IR load only commit once the instruction word is there.
        alusrcb     = 2'b01;
        irwrite_raw = mem_rdy;
        pcwrite_raw = mem_rdy;
        state_d     = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target precomputed here into ALUOut: PC + (imm << 2).
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYPE:                  state_d = S_RTYPEEX;
          OP_BEQ:                    state_d = S_BEQ;
          OP_BNE:                    state_d = S_BNE;
          OP_ADDI, OP_ORI, OP_XORI:  state_d = S_IMMEX;
          OP_J:                      state_d = S_JUMP;
          default:                   state_d = S_FETCH;
        endcase
        illegal_raw = ~op_is_legal(op);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        // Strobe stays high for the whole hold until memory accepts.
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b00;
        aluop   = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        beq_st  = (state_q == S_BEQ);
        bne_st  = (state_q == S_BNE);
        state_d = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ORI: begin
            aluop   = ALUOP_OR;
            zeroext = 1'b1;
          end
          OP_XORI: begin
            aluop   = ALUOP_XOR;
            zeroext = 1'b1;
          end
          default: aluop = ALUOP_ADD;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pcsrc       = 2'b10;
        pcwrite_raw = 1'b1;
        state_d     = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset suppresses every write so an abandoned instruction leaves no
  // partial update behind; selects keep following the state code.
  assign pcen     = ~rst & (pcwrite_raw | (beq_st & zero) | (bne_st & ~zero));
  assign memwrite = ~rst & memwrite_raw;
  assign irwrite  = ~rst & irwrite_raw;
  assign regwrite = ~rst & regwrite_raw;
  assign illegal  = ~rst & illegal_raw;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed-vector bench for mc_ctrl. Each cycle the stimulus drives inputs
// and queues the hand-written expected output vector; a monitor pops and
// compares on the falling edge.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, zeroext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .zero(zero), .pcen(pcen), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .zeroext(zeroext), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal),
    .state(state)
  );

  // {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
  //  alusrca, alusrcb, zeroext, pcsrc, aluop, illegal}
  logic [20:0] act;
  assign act = {state, pcen, iord, memwrite, irwrite, regdst, memtoreg,
                regwrite, alusrca, alusrcb, zeroext, pcsrc, aluop, illegal};

  typedef struct {
    logic [20:0] exp;
    string       name;
  } item_t;
  item_t sb_q[$];

  int tests = 0;
  int fails = 0;

  function automatic logic [20:0] ex(
    input logic [3:0] st, input logic pc_en, input logic io_rd,
    input logic mw, input logic irw, input logic rd, input logic mtr,
    input logic rw, input logic asa, input logic [1:0] asb,
    input logic ze, input logic [1:0] pcs, input logic [2:0] aop,
    input logic ill);
    ex = {st, pc_en, io_rd, mw, irw, rd, mtr, rw, asa, asb, ze, pcs, aop, ill};
  endfunction

  // Monitor: compare one queued expectation per falling edge.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        tests++;
        if (act !== it.exp) begin
          fails++;
          $display("FAIL %s: got %b want %b", it.name, act, it.exp);
        end else begin
          $display("[TB] ok %s state=%0d", it.name, state);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic [5:0] o, input logic z,
                     input logic rdy, input logic [20:0] e, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    rst       = r;
    op        = o;
    zero      = z;
    mem_ready = rdy;
    it.exp    = e;
    it.name   = nm;
    sb_q.push_back(it);
  endtask

  logic [20:0] e_fetch, e_fetch_off, e_decode, e_decode_ill, e_memadr;
  logic [20:0] e_memrd, e_memwb, e_memwr, e_memwr_off, e_rtex, e_rtwb;
  logic [20:0] e_beq1, e_beq0, e_bne1, e_bne0, e_ori, e_xori, e_addi;
  logic [20:0] e_immwb, e_jump, e_fetch_hold;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ORI = 6'b001101, XORI = 6'b001110, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  initial begin
    //                st   pce io mw irw rd mtr rw asa asb   ze pcs    aop    ill
    e_fetch      = ex(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 3'b000, 0);
    e_fetch_off  = ex(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 3'b000, 0);
    e_fetch_hold = e_fetch_off;
    e_decode     = ex(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 3'b000, 0);
    e_decode_ill = ex(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 3'b000, 1);
    e_memadr     = ex(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0);
    e_memrd      = ex(4'd3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    e_memwb      = ex(4'd4, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    e_memwr      = ex(4'd5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    e_memwr_off  = ex(4'd5, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    e_rtex       = ex(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 3'b010, 0);
    e_rtwb       = ex(4'd7, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    e_beq1       = ex(4'd8, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 3'b001, 0);
    e_beq0       = ex(4'd8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 3'b001, 0);
    e_bne1       = ex(4'd12, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 3'b001, 0);
    e_bne0       = ex(4'd12, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01, 3'b001, 0);
    e_ori        = ex(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 3'b011, 0);
    e_xori       = ex(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 3'b100, 0);
    e_addi       = ex(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0);
    e_immwb      = ex(4'd10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 3'b000, 0);
    e_jump       = ex(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 3'b000, 0);

    rst = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);

    // Reset held two cycles: FETCH selects, all enables off.
    cyc(1, LW, 0, 1, e_fetch_off, "rst_hold_0");
    cyc(1, LW, 0, 1, e_fetch_off, "rst_hold_1");

    // lw: 0,1,2,3,4 then FETCH on cycle 6.
    cyc(0, LW, 0, 1, e_fetch,  "lw_fetch");
    cyc(0, LW, 0, 1, e_decode, "lw_decode");
    cyc(0, LW, 0, 1, e_memadr, "lw_memadr");
    cyc(0, LW, 0, 1, e_memrd,  "lw_memrd");
    cyc(0, LW, 0, 1, e_memwb,  "lw_memwb");

    // R-type.
    cyc(0, RT, 0, 1, e_fetch,  "lw_back_fetch");
    cyc(0, RT, 0, 1, e_decode, "rt_decode");
    cyc(0, RT, 0, 1, e_rtex,   "rt_ex");
    cyc(0, RT, 0, 1, e_rtwb,   "rt_wb");

    // Branches.
    cyc(0, BEQ, 0, 1, e_fetch,  "beq1_fetch");
    cyc(0, BEQ, 0, 1, e_decode, "beq1_decode");
    cyc(0, BEQ, 1, 1, e_beq1,   "beq_taken");
    cyc(0, BEQ, 0, 1, e_fetch,  "beq0_fetch");
    cyc(0, BEQ, 0, 1, e_decode, "beq0_decode");
    cyc(0, BEQ, 0, 1, e_beq0,   "beq_not_taken");
    cyc(0, BNE, 0, 1, e_fetch,  "bne1_fetch");
    cyc(0, BNE, 0, 1, e_decode, "bne1_decode");
    cyc(0, BNE, 0, 1, e_bne1,   "bne_taken");
    cyc(0, BNE, 1, 1, e_fetch,  "bne0_fetch");
    cyc(0, BNE, 1, 1, e_decode, "bne0_decode");
    cyc(0, BNE, 1, 1, e_bne0,   "bne_not_taken");

    // Immediates.
    cyc(0, ORI, 0, 1, e_fetch,  "ori_fetch");
    cyc(0, ORI, 0, 1, e_decode, "ori_decode");
    cyc(0, ORI, 0, 1, e_ori,    "ori_ex");
    cyc(0, ORI, 0, 1, e_immwb,  "ori_wb");
    cyc(0, XORI, 0, 1, e_fetch,  "xori_fetch");
    cyc(0, XORI, 0, 1, e_decode, "xori_decode");
    cyc(0, XORI, 0, 1, e_xori,   "xori_ex");
    cyc(0, XORI, 0, 1, e_immwb,  "xori_wb");
    cyc(0, ADDI, 0, 1, e_fetch,  "addi_fetch");
    cyc(0, ADDI, 0, 1, e_decode, "addi_decode");
    cyc(0, ADDI, 0, 1, e_addi,   "addi_ex");
    cyc(0, ADDI, 0, 1, e_immwb,  "addi_wb");

    // Jump.
    cyc(0, J, 0, 1, e_fetch,  "j_fetch");
    cyc(0, J, 0, 1, e_decode, "j_decode");
    cyc(0, J, 0, 1, e_jump,   "j_jump");

    // Illegal opcode: pulse in DECODE, straight back to FETCH.
    cyc(0, BAD, 0, 1, e_fetch,      "ill_fetch");
    cyc(0, BAD, 0, 1, e_decode_ill, "ill_decode");
    cyc(0, BAD, 0, 1, e_fetch,      "ill_back_fetch");
    cyc(0, SW,  0, 1, e_decode,     "sw_decode");
    cyc(0, SW,  0, 1, e_memadr,     "sw_memadr");
    cyc(0, SW,  0, 1, e_memwr,      "sw_memwr");

    // Reset in MEMWR: store strobe suppressed, FETCH next.
    cyc(0, SW, 0, 1, e_fetch,     "sw2_fetch");
    cyc(0, SW, 0, 1, e_decode,    "sw2_decode");
    cyc(0, SW, 0, 1, e_memadr,    "sw2_memadr");
    cyc(1, SW, 0, 1, e_memwr_off, "sw2_rst_in_memwr");
    cyc(0, SW, 0, 1, e_fetch,     "sw2_after_rst");

`ifdef MC_CTRL_MEM_WAIT_EN
    // sw with three wait cycles in MEMWR: memwrite high four cycles.
    cyc(0, SW, 0, 1, e_decode, "w_sw_decode");
    cyc(0, SW, 0, 1, e_memadr, "w_sw_memadr");
    cyc(0, SW, 0, 0, e_memwr,  "w_sw_memwr_wait0");
    cyc(0, SW, 0, 0, e_memwr,  "w_sw_memwr_wait1");
    cyc(0, SW, 0, 0, e_memwr,  "w_sw_memwr_wait2");
    cyc(0, SW, 0, 1, e_memwr,  "w_sw_memwr_done");
    // FETCH hold, then reset during the hold.
    cyc(0, SW, 0, 0, e_fetch_hold, "w_fetch_hold");
    cyc(1, SW, 0, 0, e_fetch_off,  "w_fetch_hold_rst");
    cyc(0, LW, 0, 0, e_fetch_hold, "w_fetch_after_rst_hold");
    cyc(0, LW, 0, 1, e_fetch,      "w_fetch_ready");
    cyc(0, LW, 0, 1, e_decode,     "w_lw_decode");
    cyc(0, LW, 0, 1, e_memadr,     "w_lw_memadr");
    cyc(0, LW, 0, 0, e_memrd,      "w_lw_memrd_wait");
    cyc(0, LW, 0, 1, e_memrd,      "w_lw_memrd_done");
    cyc(0, LW, 0, 1, e_memwb,      "w_lw_memwb");
`endif

    @(negedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
